// File: rtl/alu_issue_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_issue_sequencer_if
// Host-side instruction handshake into the ALU issue sequencer.
//   instr_in     16-bit instruction {op[15:12], a[11:8], b[7:4], c[3:0]}
//   instr_valid  instr_in carries an instruction this cycle
//   instr_ready  sequencer queue can accept (combinational, = !full)
// Modports: master = instruction source, slave = sequencer.
// -----------------------------------------------------------------------------
interface alu_issue_sequencer_if;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;

   modport master (output instr_in, output instr_valid, input instr_ready);
   modport slave  (input instr_in, input instr_valid, output instr_ready);
endinterface

// File: rtl/alu_issue_sequencer.sv
// -----------------------------------------------------------------------------
// alu_issue_sequencer
// Queues 16-bit ALU instructions from a host and issues them to the ALU one at
// a time, holding each for EXEC_LAT cycles. Illegal opcodes are dropped at pop
// time and flagged on the sticky err_illegal output.
//
// Optional feature macro: ALU_SEQ_PERF_CNT_EN adds saturating perf counters
// perf_issued / perf_illegal. Without it those ports and counters do not exist.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   host          slave modport: instr_in / instr_valid / instr_ready
//   flush         discard all queued instructions (a simultaneous push is lost)
//   halt          block new issues; queue keeps accepting
//   clr_err       clear err_illegal (an illegal pop in the same cycle wins)
//   alu_instr     registered instruction to the ALU, holds last issued value
//   alu_issue     1-cycle pulse, alu_instr is new
//   done          1-cycle pulse, issued instruction completed EXEC_LAT cycles
//   busy          executing or queue non-empty
//   err_illegal   sticky, an illegal opcode was popped
//   perf_issued   legal instructions issued (macro only)
//   perf_illegal  illegal instructions dropped (macro only)
// -----------------------------------------------------------------------------
module alu_issue_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int EXEC_LAT   = 2,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_issue_sequencer_if.slave host,
   input  logic                flush,
   input  logic                halt,
   input  logic                clr_err,
   output logic [15:0]         alu_instr,
   output logic                alu_issue,
   output logic                done,
   output logic                busy,
   output logic                err_illegal
`ifdef ALU_SEQ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    perf_issued,
   output logic [CNT_W-1:0]    perf_illegal
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(EXEC_LAT - 1);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF: is_legal = 1'b1;
         default:                                 is_legal = 1'b0;
      endcase
   endfunction

   // --- state ---------------------------------------------------------------
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [15:0]     alu_instr_q, alu_instr_d;
   logic            alu_issue_q, alu_issue_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [15:0]     mem_q [FIFO_DEPTH];

   logic            empty, full, push, pop;
   logic [15:0]     head;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // Push is refused when full even if a pop frees a slot in the same cycle.
   assign push  = host.instr_valid && !full && !flush;
   // A pop is only allowed once the execution slot is (about to be) free.
   assign pop   = !empty && !halt && !flush &&
                  ((state_q == IDLE) || (cnt_q == '0));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      alu_instr_d = alu_instr_q;
      alu_issue_d = 1'b0;
      done_d      = 1'b0;
      err_d       = err_q;

      if (state_q == EXEC) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end

      if (clr_err) begin
         err_d = 1'b0;
      end

      // A legal pop overrides the EXEC->IDLE exit above (back-to-back issue);
      // an illegal pop is discarded and leaves the FSM wherever it was heading.
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (is_legal(head[15:12])) begin
            alu_instr_d = head;
            alu_issue_d = 1'b1;
            state_d     = EXEC;
            cnt_d       = CNT_INIT;
         end else begin
            err_d = 1'b1;
         end
      end

      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         alu_instr_q <= '0;
         alu_issue_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         alu_instr_q <= alu_instr_d;
         alu_issue_q <= alu_issue_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Queue storage carries data only; validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= host.instr_in;
      end
   end

   assign host.instr_ready = !full;
   assign alu_instr        = alu_instr_q;
   assign alu_issue        = alu_issue_q;
   assign done             = done_q;
   assign busy             = (state_q == EXEC) || !empty;
   assign err_illegal      = err_q;

`ifdef ALU_SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] perf_issued_q, perf_issued_d;
   logic [CNT_W-1:0] perf_illegal_q, perf_illegal_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      perf_issued_d  = perf_issued_q;
      perf_illegal_d = perf_illegal_q;
      if (alu_issue_d) begin
         perf_issued_d = sat_inc(perf_issued_q);
      end
      if (pop && !is_legal(head[15:12])) begin
         perf_illegal_d = sat_inc(perf_illegal_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued_q  <= '0;
         perf_illegal_q <= '0;
      end else begin
         perf_issued_q  <= perf_issued_d;
         perf_illegal_q <= perf_illegal_d;
      end
   end

   assign perf_issued  = perf_issued_q;
   assign perf_illegal = perf_illegal_q;
`else
`endif

endmodule
